// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one DDR command port between NPORTS requesters,
// with a read-return tracker and a toggle-style refresh strobe generator.
module mem_port_arbiter #(
    parameter int unsigned NPORTS           = 4,
    parameter int unsigned READ_LATENCY     = 4,
    parameter int unsigned REFRESH_INTERVAL = 780
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NPORTS-1:0]      REQ,
    input  logic [28*NPORTS-1:0]   REQ_ADDR,
    input  logic [NPORTS-1:0]      REQ_WE,
    input  logic [32*NPORTS-1:0]   REQ_WDATA,
    output logic [NPORTS-1:0]      ACK,
    output logic [NPORTS-1:0]      RD_VALID,
    output logic [31:0]            RD_DATA,
    output logic [27:0]            ADDRESS_REQ,
    output logic                   WE,
    output logic [31:0]            DATA_W,
    output logic                   DO_ACT,
    input  logic                   COMMAND_LATCHED,
    input  logic [31:0]            DATA_R,
    output logic                   REFRESH_STROBE
);
    localparam int unsigned PtrW     = $clog2(NPORTS);
    localparam int unsigned TrkDepth = READ_LATENCY + 1;
    localparam int unsigned CntW     = $clog2(REFRESH_INTERVAL);

    typedef enum logic {StIdle, StIssue} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   ptr_q, ptr_d, owner_q, owner_d;
    logic [27:0]       addr_q, addr_d;
    logic              we_q, we_d, do_act_q, do_act_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              trk_vld_q [TrkDepth];
    logic              trk_vld_d [TrkDepth];
    logic [PtrW-1:0]   trk_port_q [TrkDepth];
    logic [PtrW-1:0]   trk_port_d [TrkDepth];
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              strobe_q, strobe_d;

    logic [27:0]       addr_arr  [NPORTS];
    logic [31:0]       wdata_arr [NPORTS];
    logic              winner_found, latch;
    logic [PtrW-1:0]   winner;

    for (genvar g = 0; g < NPORTS; g++) begin : g_unpack
        assign addr_arr[g]  = REQ_ADDR[28*g +: 28];
        assign wdata_arr[g] = REQ_WDATA[32*g +: 32];
    end

    assign latch = (state_q == StIssue) && COMMAND_LATCHED;

    // First requester at or after ptr, wrapping modulo NPORTS.
    always_comb begin
        winner_found = 1'b0;
        winner       = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            int unsigned idx;
            idx = int'(ptr_q) + i;
            if (idx >= NPORTS) idx = idx - NPORTS;
            if (!winner_found && REQ[PtrW'(idx)]) begin
                winner_found = 1'b1;
                winner       = PtrW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        do_act_d = do_act_q;
        unique case (state_q)
            StIdle: begin
                if (winner_found) begin
                    owner_d  = winner;
                    addr_d   = addr_arr[winner];
                    we_d     = REQ_WE[winner];
                    wdata_d  = wdata_arr[winner];
                    do_act_d = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (COMMAND_LATCHED) begin
                    do_act_d = 1'b0;
                    state_d  = StIdle;
                    ptr_d    = (owner_q == PtrW'(NPORTS - 1)) ? '0 : owner_q + PtrW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Fixed-length shift pipeline: each entry emerges exactly READ_LATENCY+1 edges later.
    always_comb begin
        trk_vld_d[0]  = latch && !we_q;
        trk_port_d[0] = owner_q;
        for (int unsigned k = 1; k < TrkDepth; k++) begin
            trk_vld_d[k]  = trk_vld_q[k-1];
            trk_port_d[k] = trk_port_q[k-1];
        end
    end

    always_comb begin
        if (cnt_q == CntW'(REFRESH_INTERVAL - 1)) begin
            cnt_d    = '0;
            strobe_d = ~strobe_q;
        end else begin
            cnt_d    = cnt_q + CntW'(1);
            strobe_d = strobe_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            owner_q  <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            do_act_q <= 1'b0;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            for (int unsigned k = 0; k < TrkDepth; k++) begin
                trk_vld_q[k]  <= 1'b0;
                trk_port_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            do_act_q <= do_act_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            for (int unsigned k = 0; k < TrkDepth; k++) begin
                trk_vld_q[k]  <= trk_vld_d[k];
                trk_port_q[k] <= trk_port_d[k];
            end
        end
    end

    always_comb begin
        ACK      = '0;
        RD_VALID = '0;
        if (latch) ACK[owner_q] = 1'b1;
        if (trk_vld_q[TrkDepth-1]) RD_VALID[trk_port_q[TrkDepth-1]] = 1'b1;
    end

    assign RD_DATA        = DATA_R;
    assign ADDRESS_REQ    = addr_q;
    assign WE             = we_q;
    assign DATA_W         = wdata_q;
    assign DO_ACT         = do_act_q;
    assign REFRESH_STROBE = strobe_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; read returns are checked against a
// scoreboard of expected {port, due cycle} entries pushed at each read latch.
module tb_mem_port_arbiter;
    localparam int NP = 4;
    localparam int RL = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NP-1:0]  req = '0;
    logic [28*NP-1:0] req_addr = '0;
    logic [NP-1:0]  req_we = '0;
    logic [32*NP-1:0] req_wdata = '0;
    logic [NP-1:0]  ack, rd_valid;
    logic [31:0]    rd_data, data_w, data_r;
    logic [27:0]    address_req;
    logic           we, do_act, refresh_strobe;
    logic           cmd_latched = 1'b0;

    int cnt = 0;
    int checks = 0;
    int errors = 0;

    typedef struct { int port; int due; } rd_exp_t;
    rd_exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;
    assign data_r = 32'hCAFEF00D ^ 32'(cnt);

    mem_port_arbiter #(
        .NPORTS(NP), .READ_LATENCY(RL), .REFRESH_INTERVAL(8)
    ) dut (
        .CLK(clk), .RST(rst), .REQ(req), .REQ_ADDR(req_addr), .REQ_WE(req_we),
        .REQ_WDATA(req_wdata), .ACK(ack), .RD_VALID(rd_valid), .RD_DATA(rd_data),
        .ADDRESS_REQ(address_req), .WE(we), .DATA_W(data_w), .DO_ACT(do_act),
        .COMMAND_LATCHED(cmd_latched), .DATA_R(data_r), .REFRESH_STROBE(refresh_strobe)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_port(input int p, input logic [27:0] a, input logic w,
                            input logic [31:0] d);
        req_addr[28*p +: 28] = a;
        req_we[p]            = w;
        req_wdata[32*p +: 32] = d;
    endtask

    task automatic push_read(input int p);
        rd_exp_t e;
        e.port = p;
        e.due  = cnt + 1 + RL;
        sb.push_back(e);
    endtask

    // Read-return monitor: every cycle RD_VALID must be either the due entry or zero.
    always @(negedge clk) begin
        #2;
        if (sb.size() > 0 && sb[0].due == cnt) begin
            chk($sformatf("rd_valid_p%0d", sb[0].port), rd_valid, NP'(1) << sb[0].port);
            chk("rd_data", rd_data, 32'hCAFEF00D ^ 32'(cnt));
            void'(sb.pop_front());
        end else begin
            chk("rd_valid_idle", rd_valid, '0);
        end
    end

    initial begin
        // Reset and idle, then refresh strobe every 8 cycles.
        step(); step();
        #1;
        chk("rst_do_act", do_act, 0);
        chk("rst_ack", ack, 0);
        chk("rst_strobe", refresh_strobe, 0);
        chk("rst_addr", address_req, 0);
        chk("rst_we", we, 0);
        rst = 1'b0;
        repeat (7) step();
        #1 chk("strobe_before_wrap", refresh_strobe, 0);
        step();
        #1 chk("strobe_first_toggle", refresh_strobe, 1);
        repeat (8) step();
        #1 chk("strobe_second_toggle", refresh_strobe, 0);

        // Single write from port 2, latched on the 3rd ISSUE cycle.
        set_port(2, 28'h1234567, 1'b1, 32'hDEADBEEF);
        req = 4'b0100;
        step();
        #1;
        chk("wr_do_act", do_act, 1);
        chk("wr_addr", address_req, 28'h1234567);
        chk("wr_we", we, 1);
        chk("wr_data", data_w, 32'hDEADBEEF);
        chk("wr_ack_early", ack, 0);
        set_port(2, 28'h0, 1'b0, 32'h0);
        step();
        #1;
        chk("wr_hold_addr", address_req, 28'h1234567);
        chk("wr_hold_data", data_w, 32'hDEADBEEF);
        step();
        cmd_latched = 1'b1;
        #1 chk("wr_ack", ack, 4'b0100);
        req = '0;
        step();
        cmd_latched = 1'b0;
        #1;
        chk("wr_do_act_low", do_act, 0);
        chk("wr_ack_gone", ack, 0);

        // Single read from port 1; a latch seen in IDLE afterwards must be ignored.
        set_port(1, 28'h0ABCDEF, 1'b0, 32'h0);
        req = 4'b0010;
        step();
        #1;
        chk("rd_do_act", do_act, 1);
        chk("rd_we", we, 0);
        chk("rd_addr", address_req, 28'h0ABCDEF);
        cmd_latched = 1'b1;
        #1 chk("rd_ack", ack, 4'b0010);
        push_read(1);
        req = '0;
        step();
        #1;
        chk("idle_latch_ack", ack, 0);
        chk("idle_do_act", do_act, 0);
        step();
        cmd_latched = 1'b0;
        repeat (6) step();

        // Round robin from a fresh reset: grant order 0,1,2,3,0 with one bubble each.
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < NP; i++) set_port(i, 28'h1000000 + 28'(i), 1'b1, 32'(i));
        req = '1;
        for (int k = 0; k < 5; k++) begin
            step();
            #1;
            chk($sformatf("rr_do_act_%0d", k), do_act, 1);
            chk($sformatf("rr_addr_%0d", k), address_req, 28'h1000000 + 28'(k % NP));
            cmd_latched = 1'b1;
            #1 chk($sformatf("rr_ack_%0d", k), ack, NP'(1) << (k % NP));
            step();
            cmd_latched = 1'b0;
            #1 chk($sformatf("rr_bubble_%0d", k), do_act, 0);
        end
        req = '0;
        step();

        // Overlapping reads: port 0 then port 3, latched two cycles apart.
        set_port(0, 28'h0000100, 1'b0, 32'h0);
        set_port(3, 28'h0000300, 1'b0, 32'h0);
        req = 4'b0001;
        step();
        cmd_latched = 1'b1;
        #1 chk("ov_ack0", ack, 4'b0001);
        push_read(0);
        req = 4'b1000;
        step();
        cmd_latched = 1'b0;
        step();
        #1 chk("ov_addr3", address_req, 28'h0000300);
        cmd_latched = 1'b1;
        #1 chk("ov_ack3", ack, 4'b1000);
        push_read(3);
        req = '0;
        step();
        cmd_latched = 1'b0;
        repeat (8) step();

        // Reset while in ISSUE with a read in flight; ptr must return to 0.
        set_port(2, 28'h0000200, 1'b0, 32'h0);
        req = 4'b0100;
        step();
        cmd_latched = 1'b1;
        #1 chk("mid_ack2", ack, 4'b0100);
        set_port(1, 28'h0000111, 1'b1, 32'h11);
        set_port(3, 28'h0000333, 1'b1, 32'h33);
        req = 4'b0010;
        step();
        cmd_latched = 1'b0;
        step();
        #1 chk("mid_issue", do_act, 1);
        rst = 1'b1;
        sb.delete();
        step();
        #1;
        chk("mid_rst_do_act", do_act, 0);
        chk("mid_rst_ack", ack, 0);
        rst = 1'b0;
        req = 4'b1010;
        step();
        #1;
        chk("post_rst_do_act", do_act, 1);
        chk("post_rst_addr", address_req, 28'h0000111);
        cmd_latched = 1'b1;
        #1 chk("post_rst_ack", ack, 4'b0010);
        req = '0;
        step();
        cmd_latched = 1'b0;
        repeat (8) step();
        chk("sb_drained", 64'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
